// File: rtl/sep_switch_allocator.sv
// Separable input-first switch allocator: per-input VC round-robin, then per-output
// input round-robin, with iSLIP pointer updates and a registered crossbar select stage.
module sep_switch_allocator #(
    parameter int PORT_NUM  = 5,
    parameter int VC_NUM    = 2,
    parameter int VC_SIZE   = $clog2(VC_NUM),
    parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 switch_request   [PORT_NUM][VC_NUM],
    input  logic [PORT_SIZE-1:0] out_port         [PORT_NUM][VC_NUM],
    input  logic [VC_SIZE-1:0]   downstream_vc    [PORT_NUM][VC_NUM],
    input  logic                 is_available     [PORT_NUM][VC_NUM],
    output logic                 valid_sel        [PORT_NUM],
    output logic [VC_SIZE-1:0]   vc_sel           [PORT_NUM],
    output logic                 xb_valid         [PORT_NUM],
    output logic [PORT_SIZE-1:0] xb_in_port       [PORT_NUM],
    output logic [VC_SIZE-1:0]   xb_downstream_vc [PORT_NUM]
);

    // Handshake: none. Requests are level inputs sampled every cycle; a grant in
    // cycle t means the input block dequeues that VC at the edge ending cycle t.

    logic [VC_SIZE-1:0]   ptr_in      [PORT_NUM];
    logic [VC_SIZE-1:0]   ptr_in_nxt  [PORT_NUM];
    logic [PORT_SIZE-1:0] ptr_out     [PORT_NUM];
    logic [PORT_SIZE-1:0] ptr_out_nxt [PORT_NUM];

    logic                 elig     [PORT_NUM][VC_NUM];
    logic                 w1_valid [PORT_NUM];
    logic [VC_SIZE-1:0]   w1       [PORT_NUM];
    logic [PORT_SIZE-1:0] tgt      [PORT_NUM];
    logic                 g_valid  [PORT_NUM];
    logic [PORT_SIZE-1:0] g        [PORT_NUM];
    logic                 granted  [PORT_NUM];

    logic                 xb_valid_nxt   [PORT_NUM];
    logic [PORT_SIZE-1:0] xb_in_port_nxt [PORT_NUM];
    logic [VC_SIZE-1:0]   xb_dvc_nxt     [PORT_NUM];

    // Out-of-range targets are rejected before they can index the credit table.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                elig[i][v] = 1'b0;
                if (switch_request[i][v] && (int'(out_port[i][v]) < PORT_NUM))
                    elig[i][v] = is_available[out_port[i][v]][downstream_vc[i][v]];
            end
        end
    end

    // Stage 1: per-input round-robin over eligible VCs starting at ptr_in.
    always_comb begin
        int                 idx;
        logic [VC_SIZE-1:0] vidx;
        idx  = 0;
        vidx = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w1_valid[i] = 1'b0;
            w1[i]       = '0;
            tgt[i]      = '0;
            for (int k = 0; k < VC_NUM; k++) begin
                idx  = (int'(ptr_in[i]) + k) % VC_NUM;
                vidx = VC_SIZE'(idx);
                if (!w1_valid[i] && elig[i][vidx]) begin
                    w1_valid[i] = 1'b1;
                    w1[i]       = vidx;
                    tgt[i]      = out_port[i][vidx];
                end
            end
        end
    end

    // Stage 2: per-output round-robin over stage-1 winners starting at ptr_out.
    always_comb begin
        int                   idx;
        logic [PORT_SIZE-1:0] pidx;
        idx  = 0;
        pidx = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            g_valid[o] = 1'b0;
            g[o]       = '0;
            for (int k = 0; k < PORT_NUM; k++) begin
                idx  = (int'(ptr_out[o]) + k) % PORT_NUM;
                pidx = PORT_SIZE'(idx);
                if (!g_valid[o] && w1_valid[pidx] && (tgt[pidx] == PORT_SIZE'(o))) begin
                    g_valid[o] = 1'b1;
                    g[o]       = pidx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < PORT_NUM; i++)
            granted[i] = 1'b0;
        for (int o = 0; o < PORT_NUM; o++)
            if (g_valid[o])
                granted[g[o]] = 1'b1;
    end

    // Grants are forced low while reset is held, regardless of requests.
    always_comb begin
        for (int i = 0; i < PORT_NUM; i++) begin
            valid_sel[i] = !rst && granted[i];
            vc_sel[i]    = (!rst && granted[i]) ? w1[i] : '0;
        end
    end

    // Only stage-2 winners move pointers; stage-1-only winners keep theirs (iSLIP).
    always_comb begin
        ptr_in_nxt  = ptr_in;
        ptr_out_nxt = ptr_out;
        for (int o = 0; o < PORT_NUM; o++) begin
            xb_valid_nxt[o]   = 1'b0;
            xb_in_port_nxt[o] = '0;
            xb_dvc_nxt[o]     = '0;
            if (g_valid[o]) begin
                ptr_out_nxt[o]    = PORT_SIZE'((int'(g[o]) + 1) % PORT_NUM);
                ptr_in_nxt[g[o]]  = VC_SIZE'((int'(w1[g[o]]) + 1) % VC_NUM);
                xb_valid_nxt[o]   = 1'b1;
                xb_in_port_nxt[o] = g[o];
                xb_dvc_nxt[o]     = downstream_vc[g[o]][w1[g[o]]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                ptr_in[i]           <= '0;
                ptr_out[i]          <= '0;
                xb_valid[i]         <= 1'b0;
                xb_in_port[i]       <= '0;
                xb_downstream_vc[i] <= '0;
            end
        end else begin
            ptr_in           <= ptr_in_nxt;
            ptr_out          <= ptr_out_nxt;
            xb_valid         <= xb_valid_nxt;
            xb_in_port       <= xb_in_port_nxt;
            xb_downstream_vc <= xb_dvc_nxt;
        end
    end

endmodule
